vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1, 25 MHz pixel clock from the PLL output.
REQ-010 SHALL have port rst_n, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-011 SHALL have port pll_locked, input, 1, PLL lock status, asynchronous to clk.
REQ-012 SHALL have port req_valid, output, 1, pixel fetch request for the current counter position.
REQ-013 SHALL have ports req_x and req_y, output, 10 each, requested pixel coordinates.
REQ-014 SHALL have port rgb_in, input, 24, pixel data returned exactly one cycle after the request.
REQ-015 SHALL have ports vga_hs_n and vga_vs_n, output, 1 each, active-low syncs.
REQ-016 SHALL have port vga_de, output, 1, display enable.
REQ-017 SHALL have port vga_rgb, output, 24, {R,G,B} 8 bits each.
REQ-018 SHALL have port frame_start, output, 1, one-cycle pulse with the first output pixel of each frame.

Function
REQ-019 SHALL synchronise pll_locked through two flops to locked_s; timing runs only while locked_s=1.
REQ-020 SHALL count h_cnt 0..H_TOTAL-1, H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); on wrap to 0, SHALL advance v_cnt.
REQ-021 SHALL count v_cnt 0..V_TOTAL-1 (525); at h_cnt=799 and v_cnt=524, both SHALL wrap to 0 in the same cycle.
REQ-022 SHALL drive req_valid=1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE, with req_x=h_cnt and req_y=v_cnt in that cycle (stage 0); both coordinates SHALL be 0 when req_valid=0.
REQ-023 SHALL assert hsync internally when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-024 SHALL assert vsync internally when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), for whole lines.
REQ-025 SHALL delay de, hsync, vsync and frame-start (h=0,v=0) through two register stages, so outputs for counter cycle n appear at cycle n+2.
REQ-026 SHALL register vga_rgb = de_stage1 ? rgb_in : 0 at the end of cycle n+1, aligning it with vga_de at n+2.
REQ-027 SHALL force vga_rgb=0 whenever vga_de=0, including porches and sync.
REQ-028 On locked_s falling, SHALL clear counters and all pipeline stages on the next edge, holding outputs idle (hs_n=1, vs_n=1, de=0, rgb=0, req_valid=0) until locked_s rises.
REQ-029 On locked_s rising, SHALL start at h=0,v=0, producing frame_start two cycles later.

Reset
REQ-030 On rst_n=0, SHALL asynchronously set h_cnt=0, v_cnt=0, sync flops=0, pipelines cleared, vga_hs_n=1, vga_vs_n=1, vga_de=0, vga_rgb=0, frame_start=0, req_valid=0, req_x=0, req_y=0.
REQ-031 Reset release mid-line SHALL restart timing identically to REQ-029, with no partial line emitted.

Structure
REQ-032 SHALL place the timing defaults and derived H_TOTAL/V_TOTAL constants in shared package vga_pkg.
REQ-033 SHALL place the pll_locked two-flop synchroniser in sub-module sync_2ff; everything else is flat.

Verification
REQ-034 Lock at t0, rgb_in=24'h00FF00 -> frame_start at lock+2 sync+2 cycles; vga_de high exactly 640 cycles per line, 480 lines.
REQ-035 Measure line -> vga_hs_n period 800 cycles, low 96 cycles, falling 656 cycles after vga_de rises.
REQ-036 Measure frame -> vga_vs_n period 420000 cycles, low 1600 cycles, starting with output line 490.
REQ-037 Model rgb_in = {req_x[7:0], req_y[7:0], 8'h5A} delayed 1 cycle -> every vga_rgb with de=1 matches the displayed (x,y); 0 elsewhere.
REQ-038 Drop pll_locked at line 200, pixel 300, for 50 cycles -> outputs idle within 4 cycles; restart at h=0,v=0 with frame_start.
REQ-039 Assert rst_n=0 mid-vsync -> outputs reach reset values immediately without a clock edge; after release, behaviour matches REQ-034.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the per-stage timing bundle.
package vga_pkg;

   localparam int H_ACTIVE_D = 640;
   localparam int H_FP_D     = 16;
   localparam int H_SYNC_D   = 96;
   localparam int H_BP_D     = 48;
   localparam int V_ACTIVE_D = 480;
   localparam int V_FP_D     = 10;
   localparam int V_SYNC_D   = 2;
   localparam int V_BP_D     = 33;

   localparam int H_TOTAL_D =
      H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
   localparam int V_TOTAL_D =
      V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

   localparam int CNT_W = 10;
   localparam int RGB_W = 24;

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
      logic fs;
   } tim_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing with a one-cycle pixel fetch and a
// two-stage output pipeline, gated by synchronised PLL lock.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pll_locked,
   output logic             req_valid,
   output logic [CNT_W-1:0] req_x,
   output logic [CNT_W-1:0] req_y,
   input  logic [RGB_W-1:0] rgb_in,
   output logic             vga_hs_n,
   output logic             vga_vs_n,
   output logic             vga_de,
   output logic [RGB_W-1:0] vga_rgb,
   output logic             frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_ON  = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_OFF =
      CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_ON  = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_OFF =
      CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic             locked_s;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   tim_t             st0;
   tim_t             st1;
   tim_t             st2;
   logic [RGB_W-1:0] rgb_q;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   // Counters idle at 0,0 while unlocked so a relock starts a clean frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!locked_s) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   always_comb begin
      st0    = '0;
      st0.de = locked_s && (h_cnt < H_VIS) && (v_cnt < V_VIS);
      st0.hs = locked_s && (h_cnt >= HS_ON) && (h_cnt < HS_OFF);
      st0.vs = locked_s && (v_cnt >= VS_ON) && (v_cnt < VS_OFF);
      st0.fs = locked_s && (h_cnt == '0) && (v_cnt == '0);
   end

   assign req_valid = st0.de;
   assign req_x     = st0.de ? h_cnt : '0;
   assign req_y     = st0.de ? v_cnt : '0;

   // rgb_in answers the stage-0 request one cycle later, alongside st1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st1   <= '0;
         st2   <= '0;
         rgb_q <= '0;
      end else if (!locked_s) begin
         st1   <= '0;
         st2   <= '0;
         rgb_q <= '0;
      end else begin
         st1   <= st0;
         st2   <= st1;
         rgb_q <= st1.de ? rgb_in : '0;
      end
   end

   assign vga_hs_n    = ~st2.hs;
   assign vga_vs_n    = ~st2.vs;
   assign vga_de      = st2.de;
   assign frame_start = st2.fs;
   assign vga_rgb     = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 16x12 raster
// (8x6 visible) so whole frames fit in a short run.
module tb_vga_timing_gen;

   localparam int HA = 8;
   localparam int HF = 2;
   localparam int HS = 3;
   localparam int HB = 3;
   localparam int VA = 6;
   localparam int VF = 2;
   localparam int VS = 2;
   localparam int VB = 2;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pll_locked;
   logic        req_valid;
   logic [9:0]  req_x;
   logic [9:0]  req_y;
   logic [23:0] rgb_in = '0;
   logic        vga_hs_n;
   logic        vga_vs_n;
   logic        vga_de;
   logic [23:0] vga_rgb;
   logic        frame_start;

   int n_vec = 0;
   int n_bad = 0;

   int cyc = 0;
   int x = 0;
   int y = 0;
   int de_run, line_len, lines_cnt, lines_pf;
   int de_rise_t, hs_fall_t, hs_period, hs_low, hs_lead;
   int vs_fall_t, vs_period, vs_low, vs_lead, fs_t;
   logic prev_de = 1'b0;
   logic prev_hs = 1'b1;
   logic prev_vs = 1'b1;

   vga_timing_gen #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pll_locked  (pll_locked),
      .req_valid   (req_valid),
      .req_x       (req_x),
      .req_y       (req_y),
      .rgb_in      (rgb_in),
      .vga_hs_n    (vga_hs_n),
      .vga_vs_n    (vga_vs_n),
      .vga_de      (vga_de),
      .vga_rgb     (vga_rgb),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   // Pixel source: answers each request one cycle later.
   always @(posedge clk)
      rgb_in <= {req_x[7:0], req_y[7:0], 8'h5A};

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ctl"},
          32'({vga_hs_n, vga_vs_n, vga_de, frame_start, req_valid}),
          32'(5'b11000));
      chk({tag, "_rgb"}, 32'(vga_rgb), 32'h0);
      chk({tag, "_req"}, 32'({req_x, req_y}), 32'h0);
   endtask

   task automatic clr_meas();
      de_run = 0; line_len = 0; lines_cnt = 0; lines_pf = 0;
      de_rise_t = 0; hs_fall_t = 0; hs_period = 0; hs_low = 0;
      hs_lead = 0; vs_fall_t = 0; vs_period = 0; vs_low = 0;
      vs_lead = 0; fs_t = 0;
   endtask

   // One clock, sampled 1 ns after the edge, with output monitoring.
   task automatic step();
      logic [23:0] exp_rgb;
      @(posedge clk);
      #1;
      cyc++;
      if (frame_start) begin
         if (lines_cnt > 0) lines_pf = lines_cnt;
         lines_cnt = 0;
         fs_t = cyc;
      end
      exp_rgb = '0;
      if (vga_de) begin
         if (!prev_de) begin
            y = frame_start ? 0 : y + 1;
            x = 0;
            de_rise_t = cyc;
            lines_cnt++;
         end
         exp_rgb = {8'(x), 8'(y), 8'h5A};
         x++;
         de_run++;
      end else if (prev_de) begin
         line_len = de_run;
         de_run = 0;
      end
      chk("rgb", 32'(vga_rgb), 32'(exp_rgb));
      if (!req_valid)
         chk("req_zero", 32'({req_x, req_y}), 32'h0);
      if (!vga_hs_n && prev_hs) begin
         hs_period = cyc - hs_fall_t;
         hs_fall_t = cyc;
         hs_lead   = cyc - de_rise_t;
      end
      if (vga_hs_n && !prev_hs) hs_low = cyc - hs_fall_t;
      if (!vga_vs_n && prev_vs) begin
         vs_period = cyc - vs_fall_t;
         vs_fall_t = cyc;
         vs_lead   = cyc - fs_t;
      end
      if (vga_vs_n && !prev_vs) vs_low = cyc - vs_fall_t;
      prev_de = vga_de;
      prev_hs = vga_hs_n;
      prev_vs = vga_vs_n;
   endtask

   // Locked_s rises two edges after pll_locked, frame_start two later.
   task automatic lock_seq(input string tag);
      pll_locked = 1'b1;
      step();
      chk({tag, "_s1"}, 32'({frame_start, req_valid}), 32'h0);
      step();
      chk({tag, "_req0"}, 32'({req_valid, req_x, req_y}),
          32'({1'b1, 10'd0, 10'd0}));
      step();
      chk({tag, "_req1"}, 32'({frame_start, req_x}),
          32'({1'b0, 10'd1}));
      step();
      chk({tag, "_fs"}, 32'({frame_start, vga_de}), 32'h3);
      chk({tag, "_pix0"}, 32'(vga_rgb), 32'h00005A);
      step();
      chk({tag, "_fs_end"}, 32'(frame_start), 32'h0);
   endtask

   initial begin
      logic found;
      rst_n = 1'b1;
      pll_locked = 1'b0;
      #1 rst_n = 1'b0;
      #1 chk_idle("rst");
      repeat (3) step();
      rst_n = 1'b1;
      repeat (4) step();
      chk_idle("unlocked");

      clr_meas();
      lock_seq("lock");
      repeat (2 * HT * VT + 16) step();
      chk("line_de", 32'(line_len), 32'(HA));
      chk("lines", 32'(lines_pf), 32'(VA));
      chk("hs_period", 32'(hs_period), 32'(HT));
      chk("hs_low", 32'(hs_low), 32'(HS));
      chk("hs_lead", 32'(hs_lead), 32'(HA + HF));
      chk("vs_period", 32'(vs_period), 32'(HT * VT));
      chk("vs_low", 32'(vs_low), 32'(VS * HT));
      chk("vs_lead", 32'(vs_lead), 32'((VA + VF) * HT));

      found = 1'b0;
      for (int i = 0; i < 2 * HT * VT && !found; i++) begin
         step();
         found = req_valid && req_x == 10'd3 && req_y == 10'd2;
      end
      chk("drop_pos", 32'(found), 32'h1);
      pll_locked = 1'b0;
      repeat (4) step();
      chk_idle("drop4");
      repeat (46) step();
      chk_idle("drop50");
      lock_seq("relock");

      found = 1'b0;
      for (int i = 0; i < 2 * HT * VT && !found; i++) begin
         step();
         found = !vga_vs_n;
      end
      chk("vs_seen", 32'(found), 32'h1);
      repeat (5) step();
      #2 rst_n = 1'b0;
      #1 chk_idle("async_rst");
      repeat (3) step();
      chk_idle("rst_hold");
      rst_n = 1'b1;
      clr_meas();
      lock_seq("post_rst");
      repeat (HT * VT + 8) step();
      chk("post_line_de", 32'(line_len), 32'(HA));
      chk("post_lines", 32'(lines_pf), 32'(VA));
      chk("post_hs_low", 32'(hs_low), 32'(HS));

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
